// File: rtl/sort_seq_ctrl.sv
// rtl/sort_seq_ctrl.sv - bubble-sort sequencer over N entries with one shared compare-swap unit
//
// Purpose: holds N entry registers and sorts them in descending order (entry 0
// ends largest) using one compare-swap per enabled CMP cycle. Each pass exits
// early if it made no swaps. Provides a start/busy/done handshake and an advance
// gate that lets the sort be stepped one comparison at a time.
//
// Ports:
//   clk       in   1           system clock, rising edge
//   rst       in   1           asynchronous active-high reset
//   start     in   1           load x and begin a sort (taken in IDLE or DONE only)
//   adv       in   1           comparison enable (1 = free-run, pulse = single-step)
//   x         in   N*W         input entries, entry i = x[W*i +: W]
//   s         out  N*W         live entry registers, same packing
//   busy      out  1           high in CMP and PEND
//   done      out  1           high in DONE until the next accepted start
//   cmp_idx   out  IW          left index of the current comparison
//   swap_cnt  out  SW          swaps performed in this sort, saturating

module sort_seq_ctrl #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int IW = $clog2(N),
  localparam int SW = $clog2(N * (N - 1) / 2 + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            adv,
  input  logic [N*W-1:0]  x,
  output logic [N*W-1:0]  s,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   cmp_idx,
  output logic [SW-1:0]   swap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_PEND,
    ST_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);
  localparam logic [SW-1:0] SW_MAX    = '1;

  state_t          state_q, state_d;
  logic [W-1:0]    r_q [N];
  logic [W-1:0]    r_d [N];
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   pass_q, pass_d;
  logic            swapped_q, swapped_d;
  logic [SW-1:0]   swap_cnt_q, swap_cnt_d;

  logic [IW-1:0]   idx_nxt;
  logic [IW-1:0]   last_idx;
  logic [W-1:0]    left_v;
  logic [W-1:0]    right_v;

  always_comb begin
    idx_nxt  = idx_q + 1'b1;
    // Each pass bubbles the smallest remaining entry to the tail, so the
    // comparison window shrinks by one per completed pass.
    last_idx = LAST_PASS - pass_q;
    left_v   = r_q[idx_q];
    right_v  = r_q[idx_nxt];
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    swapped_d  = swapped_q;
    swap_cnt_d = swap_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          for (int i = 0; i < N; i++) begin
            r_d[i] = x[W*i +: W];
          end
          idx_d      = '0;
          pass_d     = '0;
          swapped_d  = 1'b0;
          swap_cnt_d = '0;
          state_d    = ST_CMP;
        end
      end

      ST_CMP: begin
        if (adv) begin
          // Strict less-than keeps equal entries in place.
          if (left_v < right_v) begin
            r_d[idx_q]   = right_v;
            r_d[idx_nxt] = left_v;
            swapped_d    = 1'b1;
            if (swap_cnt_q != SW_MAX) begin
              swap_cnt_d = swap_cnt_q + 1'b1;
            end
          end
          if (idx_q == last_idx) begin
            state_d = ST_PEND;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end

      ST_PEND: begin
        if (!swapped_q || (pass_q == LAST_PASS)) begin
          state_d = ST_DONE;
        end else begin
          pass_d    = pass_q + 1'b1;
          idx_d     = '0;
          swapped_d = 1'b0;
          state_d   = ST_CMP;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < N; i++) begin
        r_q[i] <= '0;
      end
      idx_q      <= '0;
      pass_q     <= '0;
      swapped_q  <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      swapped_q  <= swapped_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[W*i +: W] = r_q[i];
    end
  end

  assign busy     = (state_q == ST_CMP) || (state_q == ST_PEND);
  assign done     = (state_q == ST_DONE);
  assign cmp_idx  = idx_q;
  assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb/tb_sort_seq_ctrl.sv - self-checking bench for sort_seq_ctrl

module tb_sort_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        adv;
  logic [15:0] x;
  logic [15:0] s;
  logic        busy;
  logic        done;
  logic [1:0]  cmp_idx;
  logic [2:0]  swap_cnt;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [15:0] s;
    logic [2:0]  sc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  sort_seq_ctrl #(.N(4), .W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .adv      (adv),
    .x        (x),
    .s        (s),
    .busy     (busy),
    .done     (done),
    .cmp_idx  (cmp_idx),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: descending bubble sort with early exit; lat counts one edge per
  // comparison plus one edge per end-of-pass decision.
  function automatic exp_t ref_sort(input logic [15:0] xv);
    exp_t       e;
    logic [3:0] a [4];
    logic [3:0] t;
    bit         sw;
    for (int i = 0; i < 4; i++) a[i] = xv[4*i +: 4];
    e.sc  = 3'd0;
    e.lat = 0;
    for (int p = 0; p <= 2; p++) begin
      sw = 1'b0;
      for (int i = 0; i <= 2 - p; i++) begin
        e.lat++;
        if (a[i] < a[i+1]) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t;
          e.sc++;
          sw = 1'b1;
        end
      end
      e.lat++;
      if (!sw) break;
    end
    for (int i = 0; i < 4; i++) e.s[4*i +: 4] = a[i];
    return e;
  endfunction

  task automatic launch(input logic [15:0] xv);
    sb.push_back(ref_sort(xv));
    x     = xv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, pops the expected result and compares. lat < 0 skips the
  // latency check (used when stepping).
  task automatic drain(input string name, input int lat_override);
    exp_t e;
    int   edges;
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    e = sb.pop_front();
    if (lat_override != 0) e.lat = lat_override;
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%b after %0d edges, required 1", name, done, edges);
    end
    if (e.lat > 0) begin
      n_cmp++;
      if (edges !== e.lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d edges, required %0d", name, edges, e.lat);
      end
    end
    n_cmp++;
    if (s !== e.s) begin
      n_fail++;
      $display("FAIL %s_s: got %h, required %h", name, s, e.s);
    end
    n_cmp++;
    if (swap_cnt !== e.sc) begin
      n_fail++;
      $display("FAIL %s_swap_cnt: got %0d, required %0d", name, swap_cnt, e.sc);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; adv = 1'b1; x = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s, busy, done, cmp_idx, swap_cnt} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_state: s=%h busy=%b done=%b idx=%0d sc=%0d, required all 0",
               s, busy, done, cmp_idx, swap_cnt);
    end
    // Abort mid-CMP: entries {1,2,3,4}.
    launch({4'd4, 4'd3, 4'd2, 4'd1});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (s !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || swap_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_cmp: s=%h busy=%b done=%b sc=%0d, required 0/0/0/0",
               s, busy, done, swap_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_sorted();
    adv = 1'b1;
    launch({4'd1, 4'd2, 4'd3, 4'd4});
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sorted_busy: got %b, required 1", busy);
    end
    drain("sorted", 4);
  endtask

  task automatic test_reverse();
    adv = 1'b1;
    launch({4'd4, 4'd3, 4'd2, 4'd1});
    drain("reverse", 9);
  endtask

  task automatic test_equal();
    adv = 1'b1;
    launch({4'd1, 4'd1, 4'd2, 4'd2});
    drain("equal", 4);
  endtask

  task automatic test_step();
    logic [1:0]  seq [6];
    logic [15:0] xv;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2;
    seq[3] = 2'd0; seq[4] = 2'd1; seq[5] = 2'd0;
    xv  = {4'd4, 4'd3, 4'd2, 4'd1};
    adv = 1'b0;
    launch(xv);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (s !== xv || cmp_idx !== 2'd0 || swap_cnt !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL step_frozen: s=%h idx=%0d sc=%0d busy=%b done=%b, required %h/0/0/1/0",
               s, cmp_idx, swap_cnt, busy, done, xv);
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (cmp_idx !== seq[k]) begin
        n_fail++;
        $display("FAIL step_idx_%0d: got %0d, required %0d", k, cmp_idx, seq[k]);
      end
      adv = 1'b1;
      @(posedge clk);
      @(negedge clk);
      adv = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    drain("step", -1);
    adv = 1'b1;
  endtask

  task automatic test_restart();
    adv = 1'b1;
    launch({4'd4, 4'd3, 4'd2, 4'd1});
    @(posedge clk);
    @(negedge clk);
    // start during CMP with different data must be ignored.
    x     = 16'hFFFF;
    start = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    drain("ignore_start", 6);
    // Restart from DONE with entries {5,0,9,3}.
    x     = {4'd3, 4'd9, 4'd0, 4'd5};
    start = 1'b1;
    sb.push_back(ref_sort(x));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done_drop: done=%b busy=%b, required 0/1", done, busy);
    end
    drain("restart", 9);
    n_cmp++;
    if (s !== {4'd0, 4'd3, 4'd5, 4'd9}) begin
      n_fail++;
      $display("FAIL restart_final: got %h, required 0359", s);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    @(negedge clk);
    test_reset();
    test_sorted();
    test_reverse();
    test_equal();
    test_step();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
